// File: rtl/ov7670_frame_writer_pkg.sv
// Shared types and defaults for the OV7670 ping-pong frame writer.
// The FSM encoding is visible on o_present_state, so the values are fixed.
package ov7670_frame_writer_pkg;

    localparam int unsigned H_WIDTH_DEF   = 320;
    localparam int unsigned V_WIDTH_DEF   = 240;
    localparam int unsigned PXL_WIDTH_DEF = 16;
    localparam int unsigned DROP_W        = 16;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StCapture  = 3'd2,
        StDrain    = 3'd3,
        StWaitSwap = 3'd4,
        StSwap     = 3'd5
    } state_e;

    // Per-bank word address width for an h x v frame.
    function automatic int unsigned frame_aw(input int unsigned h, input int unsigned v);
        return $clog2(h * v);
    endfunction

endpackage

// File: rtl/ov7670_frame_writer_if.sv
// Receiver-side stream, VGA frame-start, BRAM write port and status of the frame writer.
interface ov7670_frame_writer_if
    import ov7670_frame_writer_pkg::*;
#(
    parameter int unsigned H_WIDTH   = H_WIDTH_DEF,
    parameter int unsigned V_WIDTH   = V_WIDTH_DEF,
    parameter int unsigned PXL_WIDTH = PXL_WIDTH_DEF,
    parameter int unsigned AW        = frame_aw(H_WIDTH, V_WIDTH)
);
    localparam int unsigned HW = $clog2(H_WIDTH) + 1;
    localparam int unsigned VW = $clog2(V_WIDTH) + 1;

    logic                 i_enable;
    logic [PXL_WIDTH-1:0] i_pixel_data;
    logic [HW-1:0]        i_h_addr;
    logic [VW-1:0]        i_v_addr;
    logic                 i_valid;
    logic                 i_vga_frame_start;
    logic                 o_start_capture;
    logic                 o_next_frame;
    logic                 o_bram_we;
    logic [AW:0]          o_bram_addr;
    logic [PXL_WIDTH-1:0] o_bram_data;
    logic                 o_rd_bank;
    logic                 o_frame_done;
    logic [DROP_W-1:0]    o_drop_cnt;
    logic [2:0]           o_present_state;

    modport master (
        output i_enable, i_pixel_data, i_h_addr, i_v_addr, i_valid, i_vga_frame_start,
        input  o_start_capture, o_next_frame, o_bram_we, o_bram_addr, o_bram_data,
        input  o_rd_bank, o_frame_done, o_drop_cnt, o_present_state
    );

    modport slave (
        input  i_enable, i_pixel_data, i_h_addr, i_v_addr, i_valid, i_vga_frame_start,
        output o_start_capture, o_next_frame, o_bram_we, o_bram_addr, o_bram_data,
        output o_rd_bank, o_frame_done, o_drop_cnt, o_present_state
    );

endinterface

// File: rtl/ov7670_frame_writer_addr_pipe.sv
// Two-stage range check / linear address pipe: S1 registers inputs and v*H_WIDTH, S2 adds h.
// Never stalls; drop pulses one cycle after the offending strobe.
module ov7670_frame_writer_addr_pipe
    import ov7670_frame_writer_pkg::*;
#(
    parameter int unsigned H_WIDTH   = H_WIDTH_DEF,
    parameter int unsigned V_WIDTH   = V_WIDTH_DEF,
    parameter int unsigned PXL_WIDTH = PXL_WIDTH_DEF,
    parameter int unsigned AW        = frame_aw(H_WIDTH, V_WIDTH),
    parameter int unsigned HW        = $clog2(H_WIDTH) + 1,
    parameter int unsigned VW        = $clog2(V_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [HW-1:0]        h,
    input  logic [VW-1:0]        v,
    input  logic [PXL_WIDTH-1:0] data,
    input  logic                 accept,
    input  logic                 discard,
    output logic                 we,
    output logic [AW-1:0]        addr,
    output logic [PXL_WIDTH-1:0] wdata,
    output logic                 drop
);

    logic                 in_range;
    logic                 s1_we_q, s2_we_q, drop_q;
    logic [HW-1:0]        s1_h_q;
    logic [AW-1:0]        s1_base_q, s2_addr_q;
    logic [PXL_WIDTH-1:0] s1_data_q, s2_data_q;

    assign in_range = (32'(h) < H_WIDTH) && (32'(v) < V_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_we_q   <= 1'b0;
            drop_q    <= 1'b0;
            s1_h_q    <= '0;
            s1_base_q <= '0;
            s1_data_q <= '0;
            s2_we_q   <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
        end else begin
            s1_we_q   <= valid && accept && in_range;
            // Discard counts every strobe; otherwise only out-of-range ones while accepting.
            drop_q    <= valid && (discard || (accept && !in_range));
            s1_h_q    <= h;
            s1_base_q <= AW'(v) * AW'(H_WIDTH);
            s1_data_q <= data;
            s2_we_q   <= s1_we_q;
            s2_addr_q <= s1_base_q + AW'(s1_h_q);
            s2_data_q <= s1_data_q;
        end
    end

    assign we    = s2_we_q;
    assign addr  = s2_addr_q;
    assign wdata = s2_data_q;
    assign drop  = drop_q;

endmodule

// File: rtl/ov7670_frame_writer.sv
// Ping-pong frame writer: capture FSM, bank registers and saturating drop counter around the
// address pipe. Banks swap only on a VGA frame start after a complete frame has drained.
module ov7670_frame_writer
    import ov7670_frame_writer_pkg::*;
#(
    parameter int unsigned H_WIDTH   = H_WIDTH_DEF,
    parameter int unsigned V_WIDTH   = V_WIDTH_DEF,
    parameter int unsigned PXL_WIDTH = PXL_WIDTH_DEF,
    parameter int unsigned AW        = frame_aw(H_WIDTH, V_WIDTH)
) (
    input logic                  i_clk,
    input logic                  i_reset,
    ov7670_frame_writer_if.slave bus
);

    state_e            state_q, state_d;
    logic              drain_q, pend_q, wr_bank_q, rd_bank_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              last_px, accept, discard, swap;
    logic              pipe_we, pipe_drop;
    logic [AW-1:0]     pipe_addr;

    assign last_px = bus.i_valid && (32'(bus.i_h_addr) == H_WIDTH - 1)
                     && (32'(bus.i_v_addr) == V_WIDTH - 1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (bus.i_enable) state_d = StStart;
            StStart:    state_d = StCapture;
            StCapture:  if (last_px) state_d = StDrain;
            StDrain:    if (drain_q) state_d = StWaitSwap;
            StWaitSwap: if (pend_q || bus.i_vga_frame_start) state_d = StSwap;
            StSwap:     state_d = bus.i_enable ? StCapture : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        accept              = (state_q == StCapture);
        discard             = (state_q == StWaitSwap);
        swap                = (state_q == StSwap);
        bus.o_start_capture = (state_q == StStart);
        bus.o_frame_done    = swap;
        bus.o_next_frame    = swap && bus.i_enable;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            drain_q    <= 1'b0;
            pend_q     <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            drop_cnt_q <= '0;
        end else begin
            // Two DRAIN cycles cover the two pipe stages behind the last pixel.
            drain_q <= (state_q == StDrain) && !drain_q;
            if (swap) begin
                pend_q    <= 1'b0;
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
            end else if (bus.i_vga_frame_start
                         && (state_q == StDrain || state_q == StWaitSwap)) begin
                pend_q <= 1'b1;
            end
            if (pipe_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    ov7670_frame_writer_addr_pipe #(
        .H_WIDTH   (H_WIDTH),
        .V_WIDTH   (V_WIDTH),
        .PXL_WIDTH (PXL_WIDTH),
        .AW        (AW)
    ) u_addr_pipe (
        .clk     (i_clk),
        .rst     (i_reset),
        .valid   (bus.i_valid),
        .h       (bus.i_h_addr),
        .v       (bus.i_v_addr),
        .data    (bus.i_pixel_data),
        .accept  (accept),
        .discard (discard),
        .we      (pipe_we),
        .addr    (pipe_addr),
        .wdata   (bus.o_bram_data),
        .drop    (pipe_drop)
    );

    assign bus.o_bram_we       = pipe_we;
    assign bus.o_bram_addr     = {wr_bank_q, pipe_addr};
    assign bus.o_rd_bank       = rd_bank_q;
    assign bus.o_drop_cnt      = drop_cnt_q;
    assign bus.o_present_state = state_q;

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Scoreboard bench for ov7670_frame_writer; a short frame (320 x 4) keeps full-frame runs cheap.
module tb_ov7670_frame_writer;

    localparam int unsigned H_TB  = 320;
    localparam int unsigned V_TB  = 4;
    localparam int unsigned PW    = 16;
    localparam int unsigned AW_TB = $clog2(H_TB * V_TB);

    typedef struct {
        logic [AW_TB:0]  addr;
        logic [PW-1:0]   data;
        int              due;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   nchk = 0, nerr = 0, cyc = 0;
    int   n_done = 0, n_next = 0;
    int   done0, next0, exp_drop;
    logic exp_wr;
    wr_t  sb[$];
    wr_t  got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ov7670_frame_writer_if #(.H_WIDTH(H_TB), .V_WIDTH(V_TB), .PXL_WIDTH(PW)) bus ();

    ov7670_frame_writer #(
        .H_WIDTH   (H_TB),
        .V_WIDTH   (V_TB),
        .PXL_WIDTH (PW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_drop(input int n);
        exp_drop = (exp_drop + n > 65535) ? 65535 : exp_drop + n;
    endtask

    // One-cycle strobe; when wr is set the write is expected two cycles later.
    task automatic send(input int h, input int v, input logic [PW-1:0] d, input bit wr);
        wr_t e;
        int  lin;
        bus.i_valid      = 1'b1;
        bus.i_h_addr     = 10'(h);
        bus.i_v_addr     = 3'(v);
        bus.i_pixel_data = d;
        if (wr) begin
            lin    = v * int'(H_TB) + h;
            e.addr = {exp_wr, AW_TB'(lin)};
            e.data = d;
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic send_frame(input bit dis);
        for (int v = 0; v < int'(V_TB); v++) begin
            for (int h = 0; h < int'(H_TB); h++) begin
                if (dis && v == int'(V_TB) / 2 && h == 0) bus.i_enable = 1'b0;
                send(h, v, 16'($urandom), 1'b1);
            end
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_start"}, 32'(bus.o_start_capture), 0);
        check({tag, "_next"},  32'(bus.o_next_frame), 0);
        check({tag, "_we"},    32'(bus.o_bram_we), 0);
        check({tag, "_addr"},  32'(bus.o_bram_addr), 0);
        check({tag, "_data"},  32'(bus.o_bram_data), 0);
        check({tag, "_rdb"},   32'(bus.o_rd_bank), 1);
        check({tag, "_done"},  32'(bus.o_frame_done), 0);
        check({tag, "_drop"},  32'(bus.o_drop_cnt), 0);
        check({tag, "_state"}, 32'(bus.o_present_state), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_bram_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("wr_addr", 32'(bus.o_bram_addr), 32'(got.addr));
                    check("wr_data", 32'(bus.o_bram_data), 32'(got.data));
                    check("wr_latency", cyc, got.due);
                end
            end
            if (bus.o_frame_done) n_done++;
            if (bus.o_next_frame) n_next++;
        end
    end

    initial begin
        rst = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_h_addr = '0;
        bus.i_v_addr = '0;
        bus.i_pixel_data = '0;
        bus.i_vga_frame_start = 1'b0;
        exp_wr = 1'b0;
        exp_drop = 0;
        repeat (3) tick();
        @(negedge clk);
        check_rst("reset");

        // Start-up: one IDLE cycle, then a single START cycle.
        tick();
        rst = 1'b0;
        bus.i_enable = 1'b1;
        @(negedge clk);
        check("idle_state", 32'(bus.o_present_state), 0);
        check("idle_start", 32'(bus.o_start_capture), 0);
        tick();
        @(negedge clk);
        check("start_pulse", 32'(bus.o_start_capture), 1);
        check("start_state", 32'(bus.o_present_state), 1);
        tick();
        @(negedge clk);
        check("start_once", 32'(bus.o_start_capture), 0);
        check("capture_state", 32'(bus.o_present_state), 2);

        // Frame start during CAPTURE must not be remembered.
        tick();
        bus.i_vga_frame_start = 1'b1;
        tick();
        bus.i_vga_frame_start = 1'b0;

        send(5, 2, 16'hABCD, 1'b1);
        send(int'(H_TB), 0, 16'h1111, 1'b0);
        send(0, int'(V_TB), 16'h2222, 1'b0);
        add_drop(2);
        repeat (3) tick();
        @(negedge clk);
        check("drop_out_of_range", 32'(bus.o_drop_cnt), 32'(exp_drop));

        // Frame 1 into bank 0, late VGA frame start.
        send_frame(1'b0);
        @(negedge clk);
        check("drain_state", 32'(bus.o_present_state), 3);
        tick();
        tick();
        @(negedge clk);
        check("wait_state", 32'(bus.o_present_state), 4);
        for (int i = 0; i < 3; i++) send(1, 1, 16'h3333, 1'b0);
        add_drop(3);
        repeat (5) tick();
        @(negedge clk);
        check("wait_hold", 32'(bus.o_present_state), 4);
        check("drop_wait_swap", 32'(bus.o_drop_cnt), 32'(exp_drop));
        check("rd_bank_before", 32'(bus.o_rd_bank), 1);
        done0 = n_done;
        next0 = n_next;
        tick();
        bus.i_vga_frame_start = 1'b1;
        tick();
        bus.i_vga_frame_start = 1'b0;
        @(negedge clk);
        check("swap_state", 32'(bus.o_present_state), 5);
        check("swap_done", 32'(bus.o_frame_done), 1);
        check("swap_next", 32'(bus.o_next_frame), 1);
        tick();
        @(negedge clk);
        check("rd_bank_swap1", 32'(bus.o_rd_bank), 0);
        check("recapture_state", 32'(bus.o_present_state), 2);
        check("done_once", n_done - done0, 1);
        check("next_once", n_next - next0, 1);
        exp_wr = 1'b1;

        // Frame 2 into bank 1, frame start arrives during DRAIN.
        send_frame(1'b0);
        bus.i_vga_frame_start = 1'b1;
        tick();
        bus.i_vga_frame_start = 1'b0;
        @(negedge clk);
        check("drain_pulse_state", 32'(bus.o_present_state), 3);
        tick();
        @(negedge clk);
        check("wait_entry", 32'(bus.o_present_state), 4);
        tick();
        @(negedge clk);
        check("pending_swap", 32'(bus.o_present_state), 5);
        tick();
        @(negedge clk);
        check("rd_bank_swap2", 32'(bus.o_rd_bank), 1);
        exp_wr = 1'b0;

        // Frame 3: enable drops mid-frame, frame still completes and swaps, then IDLE.
        done0 = n_done;
        next0 = n_next;
        send_frame(1'b1);
        tick();
        tick();
        bus.i_vga_frame_start = 1'b1;
        tick();
        bus.i_vga_frame_start = 1'b0;
        @(negedge clk);
        check("stop_swap_state", 32'(bus.o_present_state), 5);
        check("stop_swap_done", 32'(bus.o_frame_done), 1);
        check("stop_no_next", 32'(bus.o_next_frame), 0);
        tick();
        @(negedge clk);
        check("stop_idle", 32'(bus.o_present_state), 0);
        check("rd_bank_swap3", 32'(bus.o_rd_bank), 0);
        check("stop_done_cnt", n_done - done0, 1);
        check("stop_next_cnt", n_next - next0, 0);
        exp_wr = 1'b1;

        // Pixel in IDLE: no write, not counted.
        tick();
        send(3, 0, 16'h4444, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        check("idle_drop_silent", 32'(bus.o_drop_cnt), 32'(exp_drop));
        check("idle_stays", 32'(bus.o_present_state), 0);
        check("idle_no_start", 32'(bus.o_start_capture), 0);

        // Async reset while writes are in flight.
        tick();
        bus.i_enable = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("restart_capture", 32'(bus.o_present_state), 2);
        tick();
        for (int i = 0; i < 10; i++) send(i, 0, 16'(16'h5000 + i), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_rst("async_rst");
        sb.delete();
        exp_wr = 1'b0;
        exp_drop = 0;

        // Saturation of the drop counter with out-of-range strobes in CAPTURE.
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("sat_capture", 32'(bus.o_present_state), 2);
        tick();
        for (int i = 0; i < 1000; i++) send(int'(H_TB), 0, 16'h0, 1'b0);
        add_drop(1000);
        repeat (3) tick();
        @(negedge clk);
        check("drop_1000", 32'(bus.o_drop_cnt), 32'(exp_drop));
        tick();
        for (int i = 0; i < 64540; i++) send(0, int'(V_TB), 16'h0, 1'b0);
        add_drop(64540);
        repeat (3) tick();
        @(negedge clk);
        check("drop_saturated", 32'(bus.o_drop_cnt), 32'(exp_drop));
        check("drop_ffff", 32'(bus.o_drop_cnt), 32'h0000_FFFF);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
